// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//
// Instruction-fetch stage of the RV32I pipeline. Owns the program counter,
// talks to instruction memory with a req/ready handshake plus a separate
// rvalid response pulse (one request outstanding at a time), and holds the
// IF/ID pipeline register consumed by decode. A one-entry skid buffer catches
// a response that arrives while decode is stalled on a full IF/ID. Redirects
// from decode flush IF/ID and the skid, retarget the PC, and squash any
// response still in flight.
//
// Ports:
//   clk, rst        clock (rising edge) and synchronous active-high reset
//   stall           decode cannot accept this cycle; IF/ID holds
//   redirect        taken branch/jump; flush and refetch from redirect_addr
//   redirect_addr   redirect target, low two bits ignored
//   imem_req        fetch request valid (only in the REQ state)
//   imem_addr       word-aligned fetch address (always the fetch PC)
//   imem_ready      memory accepts the request this cycle
//   imem_rvalid     response valid, one pulse per accepted request
//   imem_rdata      instruction word returned by memory
//   instruction     IF/ID instruction (NOP_INSTR when empty)
//   pc_address      IF/ID program counter of the instruction
//   instr_valid     IF/ID holds a real instruction
// ---------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic [31:0] pc_address,
  output logic        instr_valid
);

  // REQ   : presenting a request, waiting for the memory to accept it
  // WAIT  : request accepted, waiting for its rvalid pulse
  // HOLD  : response parked in the skid buffer because decode is stalled
  // DRAIN : a squashed request is still in flight; its response is dropped
  typedef enum logic [1:0] {
    ST_REQ   = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  state_t      state;
  state_t      next_state;

  logic [31:0] fetch_pc;

  // The skid buffer is full exactly when the FSM is in HOLD, so it needs no
  // separate valid bit.
  logic [31:0] skid_instr;
  logic [31:0] skid_pc;

  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_valid;

  logic        ifid_free;
  logic        rsp_accept;
  logic        load_from_mem;
  logic        load_from_skid;
  logic        load_skid;

  // IF/ID can take new data when it is empty or decode is draining it this
  // cycle. A response only counts while in WAIT; in DRAIN it is discarded.
  assign ifid_free      = ~if_valid | ~stall;
  assign rsp_accept     = (state == ST_WAIT) & imem_rvalid;
  assign load_from_mem  = rsp_accept & ifid_free;
  assign load_skid      = rsp_accept & ~ifid_free;
  assign load_from_skid = (state == ST_HOLD) & ~stall;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_REQ;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic. A redirect overrides stall. If the redirect lands while
  // a request is in flight (WAIT, or REQ being accepted this same cycle) we
  // must drain its response, unless that response is arriving right now, in
  // which case it is simply dropped and we can request immediately.
  always_comb begin
    next_state = state;
    if (redirect) begin
      case (state)
        ST_REQ:   next_state = imem_ready  ? ST_DRAIN : ST_REQ;
        ST_WAIT:  next_state = imem_rvalid ? ST_REQ   : ST_DRAIN;
        ST_HOLD:  next_state = ST_REQ;
        ST_DRAIN: next_state = imem_rvalid ? ST_REQ   : ST_DRAIN;
        default:  next_state = ST_REQ;
      endcase
    end else begin
      case (state)
        ST_REQ:   if (imem_ready)  next_state = ST_WAIT;
        ST_WAIT:  if (imem_rvalid) next_state = ifid_free ? ST_REQ : ST_HOLD;
        ST_HOLD:  if (!stall)      next_state = ST_REQ;
        ST_DRAIN: if (imem_rvalid) next_state = ST_REQ;
        default:  next_state = ST_REQ;
      endcase
    end
  end

  // Datapath: fetch PC, skid buffer and the IF/ID register. A redirect
  // flushes IF/ID to a bubble but keeps pc_address, retargets the PC, and
  // implicitly empties the skid because the FSM leaves HOLD. Without a
  // redirect, IF/ID loads from memory or the skid, otherwise it turns into a
  // bubble once decode has consumed it.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc   <= RESET_PC;
      skid_instr <= NOP_INSTR;
      skid_pc    <= RESET_PC;
      if_instr   <= NOP_INSTR;
      if_pc      <= RESET_PC;
      if_valid   <= 1'b0;
    end else if (redirect) begin
      fetch_pc <= {redirect_addr[31:2], 2'b00};
      if_instr <= NOP_INSTR;
      if_valid <= 1'b0;
    end else begin
      if (rsp_accept) begin
        fetch_pc <= fetch_pc + 32'd4;
      end
      if (load_skid) begin
        skid_instr <= imem_rdata;
        skid_pc    <= fetch_pc;
      end
      if (load_from_mem) begin
        if_instr <= imem_rdata;
        if_pc    <= fetch_pc;
        if_valid <= 1'b1;
      end else if (load_from_skid) begin
        if_instr <= skid_instr;
        if_pc    <= skid_pc;
        if_valid <= 1'b1;
      end else if (if_valid && !stall) begin
        if_instr <= NOP_INSTR;
        if_valid <= 1'b0;
      end
    end
  end

  // Outputs: the request is only raised in REQ, and the address is always
  // the fetch PC so it stays stable while waiting for ready.
  always_comb begin
    imem_req    = (state == ST_REQ);
    imem_addr   = fetch_pc;
    instruction = if_instr;
    pc_address  = if_pc;
    instr_valid = if_valid;
  end

endmodule
